// File: rtl/fifo_control.sv
// Elastic pre-fill buffer: a single-clock circular FIFO that is written every cycle
// and replays the stream THRESH cycles later. Build option: FIFO_CONTROL_ZERO_OUT_EN.
//
// state  | meaning
// FILL   | collecting the first THRESH words, no reads
// STREAM | one read per edge while the FIFO is non-empty; left only through reset
module fifo_control #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int THRESH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  output logic              rd_en,
  output logic [DATA_W-1:0] data_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              rd_go;
  logic              wr_go;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // The FILL->STREAM edge also performs the first read, judged on the pre-edge count.
  always_comb begin
    state_nxt = state;
    rd_go     = 1'b0;
    case (state)
      FILL: begin
        if (count >= THRESH_C) begin
          state_nxt = STREAM;
          rd_go     = (count != '0);
        end
      end
      STREAM: begin
        rd_go = (count != '0);
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
    wr_go = (count != DEPTH_C) || rd_go;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_go) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_go) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_go, rd_go})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; a write landing in word 0 during reset is overwritten by the
  // first real write, which also targets address 0.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_en    <= 1'b0;
      data_out <= '0;
    end else begin
      rd_en <= rd_go;
      if (rd_go) begin
        data_out <= mem[rd_ptr];
      end else begin
`ifdef FIFO_CONTROL_ZERO_OUT_EN
        data_out <= '0;
`else
        data_out <= data_out;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fifo_control.sv
// Self-checking bench for fifo_control: table-driven pre-fill vectors, hand sequences
// for steady stream and mid-stream reset, and random traffic against a queue model.
module tb_fifo_control;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int THRESH = 16;
  localparam int NVEC   = 24;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_control #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .THRESH(THRESH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .rd_en   (rd_en),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of accepted words plus a "has started streaming" flag.
  logic [DATA_W-1:0] q [$];
  bit                streaming;
  logic              m_rd;
  logic [DATA_W-1:0] m_dout;

  typedef struct {
    logic [DATA_W-1:0] din;
    logic              exp_rd_en;
    logic [DATA_W-1:0] exp_dout;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic logic [DATA_W-1:0] pat(input int k);
    return DATA_W'((k % 17) + 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [DATA_W-1:0] d);
    int  sz;
    bit  rd;
    bit  wr;
    if (r) begin
      q.delete();
      streaming = 0;
      m_rd      = 1'b0;
      m_dout    = '0;
    end else begin
      sz = q.size();
      rd = (streaming || sz >= THRESH) && sz > 0;
      if (sz >= THRESH) streaming = 1;
      wr = (sz < DEPTH) || rd;
      if (rd) begin
        m_dout = q.pop_front();
      end else begin
`ifdef FIFO_CONTROL_ZERO_OUT_EN
        m_dout = '0;
`endif
      end
      m_rd = rd;
      if (wr) q.push_back(d);
    end
  endtask

  task automatic step(input logic r, input logic [DATA_W-1:0] d);
    rst_n   = r;
    data_in = d;
    @(posedge clk);
    #1;
    model_edge(r, d);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rd_en"}, 32'(rd_en), 32'(m_rd));
    check({tag, "_data_out"}, 32'(data_out), 32'(m_dout));
    check({tag, "_count"}, 32'(dut.count), 32'(q.size()));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b1;
    data_in = '0;
    model_edge(1'b1, '0);

    for (int e = 1; e <= NVEC; e++) begin
      tbl[e-1].din       = pat(e - 1);
      tbl[e-1].exp_rd_en = (e > THRESH);
      tbl[e-1].exp_dout  = (e > THRESH) ? pat(e - 1 - THRESH) : '0;
    end

    // Held in reset with toggling input
    for (int i = 0; i < 150; i++) begin
      step(1'b1, i[0] ? 16'hA5A5 : 16'h5A5A);
      check("reset_rd_en", 32'(rd_en), 32'd0);
      check("reset_data_out", 32'(data_out), 32'd0);
    end

    // Pre-fill latency from the vector table
    for (int i = 0; i < NVEC; i++) begin
      step(1'b0, tbl[i].din);
      check("prefill_rd_en", 32'(rd_en), 32'(tbl[i].exp_rd_en));
      check("prefill_data_out", 32'(data_out), 32'(tbl[i].exp_dout));
    end

    // Steady stream, well past two pointer wraps
    for (int e = NVEC + 1; e <= NVEC + 200; e++) begin
      step(1'b0, pat(e - 1));
      check("steady_rd_en", 32'(rd_en), 32'd1);
      check("steady_data_out", 32'(data_out), 32'(pat(e - 1 - THRESH)));
      check("steady_count", 32'(dut.count), 32'(THRESH));
    end

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b1;
    #1;
    check("async_rd_en", 32'(rd_en), 32'd0);
    check("async_data_out", 32'(data_out), 32'd0);
    check("async_count", 32'(dut.count), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'hDEAD);

    for (int e = 1; e <= THRESH + 6; e++) begin
      step(1'b0, pat(e + 4));
      check("rerun_rd_en", 32'(rd_en), 32'(e > THRESH));
      check("rerun_data_out", 32'(data_out),
            (e > THRESH) ? 32'(pat(e + 4 - THRESH)) : 32'd0);
      check_model("rerun_model");
    end

    // Random data with occasional resets
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0, DATA_W'($urandom));
      check_model("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_control.md
# fifo_control

Elastic buffer that captures a continuous 16-bit sample stream on every clock and replays it downstream once a fixed pre-fill level has been reached. It sits between the input sample source and the LDPC processing core. It turns a free-running input into a stream delayed by exactly THRESH cycles, with a valid strobe. Internally it is a single-clock circular FIFO with a two-state fill/stream controller.

## Interface
- DATA_W, 16: width of data_in, data_out and memory words.
- DEPTH, 32: FIFO depth in words; power of two, greater than THRESH.
- THRESH, 16: fill level that starts streaming; 1 ≤ THRESH < DEPTH.

- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  reset. Asynchronous, active-high: 1 = reset.
- data_in  input  DATA_W  sample written into the FIFO on every non-reset rising edge.
- rd_en  output  1  registered valid strobe. When 1, data_out holds a word popped on that edge.
- data_out  output  DATA_W  registered FIFO read data.

## Operation
- Storage: DEPTH×DATA_W memory, not reset.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- Write side: internal write request is 1 on every edge while out of reset.
  - If count < DEPTH: mem[wr_ptr] <= data_in, then wr_ptr++.
  - If count == DEPTH (full): the word is dropped and wr_ptr holds.
- State machine (2 states):
  - FILL is the reset state. No reads. Moves to STREAM on the edge where count ≥ THRESH before the edge.
  - STREAM: read request is 1 every edge. A read occurs if count > 0; then data_out <= mem[rd_ptr] and rd_ptr++. STREAM never returns to FILL except via reset.
- rd_en is registered: 1 on the edge a read occurs, 0 otherwise (FILL, or STREAM with empty FIFO).
- count rules:
  - write only: +1.
  - read only: −1.
  - both: unchanged.
  - neither: unchanged.
  - A read and a write in the same edge are both legal, including at count == DEPTH (the read frees a slot, so the write is accepted).
- With continuous input, count settles at THRESH and stays there. The FIFO never fills or empties in steady state.

## Timing
- Reset values: rd_en = 0, data_out = 0, wr_ptr = rd_ptr = 0, count = 0, state = FILL.
- Reset asserted mid-operation clears all state immediately (asynchronously).
  - The first write after release goes to address 0.
  - Data already in memory is ignored.
- Edges are numbered 1, 2, … starting from the first rising edge with rst_n = 0.
  - Edges 1..THRESH: data_in is written; rd_en stays 0.
  - Edge THRESH+1: state becomes STREAM and the first read occurs. data_out = word captured at edge 1, rd_en = 1.
  - The FSM transition and the first read happen on the same edge. The read uses the pre-edge count.
- Steady state: data_out at edge n equals data_in sampled at edge n−THRESH. rd_en stays continuously 1.
- Throughput: one word in and one word out per clock.

## Configuration
- Macro FIFO_CONTROL_ZERO_OUT_EN.
  - Defined: data_out is driven to 0 on any edge where no read occurs (rd_en = 0).
  - Undefined (default): data_out holds its last read value when rd_en = 0.
  - rd_en timing is identical in both builds.

## Test plan
- Reset: hold rst_n = 1 for 150 cycles while data_in toggles -> rd_en = 0, data_out = 0 throughout; no state change.
- Pre-fill latency: after release, drive the cyclic 17-word pattern 0x0001..0x0011 -> rd_en = 0 for edges 1–16 and rises at edge 17 with data_out = word captured at edge 1.
- Steady stream: continue the cyclic pattern for 200 cycles -> rd_en stays 1, data_out equals data_in delayed 16 edges, pattern wraps 0x0011 -> 0x0001 cleanly, internal count stays 16.
- Pointer wrap: run more than 2×DEPTH cycles -> no lost or duplicated words across the address 31 -> 0 wrap.
- Mid-stream reset: assert rst_n for 3 cycles during STREAM -> rd_en and data_out go to 0 asynchronously. After release, the 16-edge pre-fill repeats and the first output is the first word captured after release.
- Macro check: with FIFO_CONTROL_ZERO_OUT_EN defined, data_out = 0 during edges 1–16 after release. Without the macro, after a mid-stream reset, data_out stays 0 until the first read, since reset clears it.
